// File: rtl/serial_adder_fsm_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared constants for the bit-serial adder: default operand width and the
// FSM state encodings (kept as plain constants for compatibility with the
// legacy encoding).
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_adder_fsm_if.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm_if
// Operand/result handshake bundle for serial_adder_fsm.
//   in_valid/in_ready : operand pair a/b handshake (producer -> adder)
//   a, b              : WIDTH-bit operands
//   out_valid/out_ready : result handshake (adder -> consumer)
//   sum, carry        : WIDTH-bit sum and carry-out
// Modports: slave = adder side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface serial_adder_fsm_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry
    );

endinterface

// File: rtl/serial_adder_fsm_fa_cell.sv
// -----------------------------------------------------------------------------
// ha_cell / fa_cell
// ha_cell : 1-bit half adder (a_i, b_i -> s_o, c_o).
// fa_cell : 1-bit full adder from two half adders plus an OR of their carries
//           (a_i, b_i, c_i -> s_o, c_o). Single datapath slice of the adder.
// -----------------------------------------------------------------------------
module ha_cell (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic s1;
    logic c1;
    logic c2;

    ha_cell u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s1),
        .c_o (c1)
    );

    ha_cell u_ha1 (
        .a_i (s1),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c2)
    );

    assign c_o = c1 | c2;

endmodule

// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
// Bit-serial WIDTH-bit adder. Accepts an operand pair on the input handshake,
// adds LSB-first one bit per clock through a single fa_cell with the carry
// held in a flop, then presents {carry, sum} on the output handshake until
// the consumer accepts it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any addition in flight)
//   bus   : serial_adder_fsm_if.slave (in_valid/in_ready/a/b,
//           out_valid/out_ready/sum/carry)
// -----------------------------------------------------------------------------
module serial_adder_fsm
    import serial_add_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_fsm_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_shift;

    fa_cell u_fa (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first (LSB) result
    // has reached bit 0. A 1-bit register is simply replaced.
    if (WIDTH == 1) begin : g_shift_w1
        assign sum_shift = fa_s;
    end else begin : g_shift_wn
        assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                sum_d   = sum_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
module tb_serial_adder_fsm;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_adder_fsm_if #(.WIDTH(W)) bus ();

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every cycle the result is presented (so held values
    // under backpressure are checked too); pops when the consumer accepts.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got sum %0h carry %0b expected no result", bus.sum, bus.carry);
            end else begin
                check("result_sum", 32'(bus.sum), 32'(sb_q[0].sum));
                check("result_carry", 32'(bus.carry), 32'(sb_q[0].carry));
                if (bus.out_ready === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec,
                         input int hold, input bit pulse);
        int lat;
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        sb_q.push_back('{sum: es, carry: ec});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'hEE;
        bus.b        = 8'hEE;
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            bus.in_valid = pulse && (lat == 3);
            bus.a        = 8'h11;
            bus.b        = 8'h22;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(lat), 32'(W));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        check("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 8'h00, 1'b1, 0, 1'b0);
        do_op(8'hA5, 8'h5A, 8'hFF, 1'b0, 0, 1'b0);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, 0, 1'b0);
        do_op(8'h01, 8'h01, 8'h02, 1'b0, 0, 1'b0);
        do_op(8'h3C, 8'h0F, 8'h4B, 1'b0, 5, 1'b0);
        do_op(8'h01, 8'h02, 8'h03, 1'b0, 0, 1'b1);
        do_op(8'hC8, 8'h64, 8'h2C, 1'b1, 0, 1'b0);

        // Abort an addition mid-shift; no result may appear.
        bus.in_valid = 1'b1;
        bus.a        = 8'h55;
        bus.b        = 8'h0F;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_carry", 32'(bus.carry), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_result", 32'(bus.out_valid), 32'd0);

        do_op(8'h7F, 8'h01, 8'h80, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
